min_window_tracker: RTL



---
 rtl/min_window_tracker_if.sv | 68 ++++++
 rtl/min_window_tracker.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/min_window_tracker_if.sv
// -----------------------------------------------------------------------------
// min_window_tracker_if
// Stream bundle for min_window_tracker: a valid/ready input carrying the
// per-sample minimum from the upstream stage, and a valid/ready output carrying
// the sliding-window minimum.
//
// Parameters
//   DW   data width
//   WIN  window depth (AW = $clog2(WIN) is derived)
//
// Signals
//   in_valid / in_data / in_ready       sample stream into the tracker
//   out_valid / out_ready               result handshake
//   out_min                             window minimum
//   out_fill                            samples in the window, 1..WIN
//   out_age                             age of the minimum (MINWIN_AGE_EN only)
//
// Modports
//   slave   the tracker itself
//   master  the surrounding producer/consumer (or a testbench)
//
// Build option: MINWIN_AGE_EN adds out_age.
// -----------------------------------------------------------------------------
interface min_window_tracker_if #(
  parameter int DW  = 8,
  parameter int WIN = 4
);
  localparam int AW = $clog2(WIN);

  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_min;
  logic [AW:0]   out_fill;
`ifdef MINWIN_AGE_EN
  logic [AW-1:0] out_age;
`endif

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    input  out_ready,
    output out_min,
    output out_fill
`ifdef MINWIN_AGE_EN
    ,
    output out_age
`endif
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    output out_ready,
    input  out_min,
    input  out_fill
`ifdef MINWIN_AGE_EN
    ,
    input  out_age
`endif
  );
endinterface

// File: rtl/min_window_tracker.sv
// -----------------------------------------------------------------------------
// min_window_tracker
// Keeps the last WIN upstream minimum results in a ring buffer and reports the
// minimum over that sliding window. A single comparator walks the window from
// newest to oldest, one entry per cycle, then the result is held on a
// valid/ready output until the consumer takes it.
//
// Parameters
//   DW   data width (matches the upstream d width)
//   WIN  window depth, >= 2
//
// Ports
//   clk   system clock, rising edge
//   rst   asynchronous active-high reset
//   clr   synchronous window flush; overrides every other event
//   bus   min_window_tracker_if.slave
//           in_valid/in_data/in_ready   : sample accepted only in IDLE
//           out_valid/out_ready         : result held until accepted
//           out_min/out_fill[/out_age]  : updated only when a result is loaded
//
// Build option: define MINWIN_AGE_EN to track and report the age of the
// minimum (0 = newest) on out_age. Without it, the age register and port are
// absent; out_min, out_fill and timing do not change.
// -----------------------------------------------------------------------------
module min_window_tracker #(
  parameter int DW  = 8,
  parameter int WIN = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  min_window_tracker_if.slave  bus
);
  localparam int AW = $clog2(WIN);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Ring-buffer slot holding the entry of a given age. wp points one past the
  // newest entry, so age k lives at (wp - 1 - k) mod WIN. The sum is formed in
  // AW+1 bits, which always covers the 0..2*WIN-2 range, so a single
  // conditional subtract performs the wrap even for non power-of-two WIN.
  function automatic logic [AW-1:0] age_idx(input logic [AW-1:0] wp,
                                            input logic [AW-1:0] age);
    logic [AW:0] sum;
    sum = {1'b0, wp} + (AW+1)'(WIN - 1) - {1'b0, age};
    if (sum >= (AW+1)'(WIN)) begin
      sum = sum - (AW+1)'(WIN);
    end else begin
      sum = sum;
    end
    return sum[AW-1:0];
  endfunction

  state_t        state_r, state_s;
  logic [DW-1:0] buf_r [WIN];
  logic [AW-1:0] wptr_r, wptr_s;
  logic [AW:0]   fill_r, fill_s;
  logic [DW-1:0] acc_r, acc_s;
  logic [AW-1:0] k_r, k_s;
  logic          out_valid_r, out_valid_s;
  logic [DW-1:0] out_min_r, out_min_s;
  logic [AW:0]   out_fill_r, out_fill_s;
  logic          wr_en_s;
  logic [AW:0]   fill_inc_s;
  logic [AW-1:0] wptr_inc_s;
  logic [DW-1:0] cand_s;
  logic          scan_last_s;
`ifdef MINWIN_AGE_EN
  logic [AW-1:0] acc_age_r, acc_age_s;
  logic [AW-1:0] out_age_r, out_age_s;
`endif

  // Incremented pointer/fill and the buffer entry under the comparator.
  always_comb begin
    fill_inc_s = fill_r;
    wptr_inc_s = wptr_r;
    // fill saturates at WIN; from then on every write evicts the oldest entry
    if (fill_r == (AW+1)'(WIN)) begin
      fill_inc_s = fill_r;
    end else begin
      fill_inc_s = fill_r + (AW+1)'(1);
    end
    if (wptr_r == AW'(WIN - 1)) begin
      wptr_inc_s = '0;
    end else begin
      wptr_inc_s = wptr_r + AW'(1);
    end
    cand_s      = buf_r[age_idx(wptr_r, k_r)];
    scan_last_s = ({1'b0, k_r} == (fill_r - (AW+1)'(1)));
  end

  // Next-state and next-datapath logic for the IDLE/SCAN/HOLD sequencer.
  always_comb begin
    state_s     = state_r;
    wptr_s      = wptr_r;
    fill_s      = fill_r;
    acc_s       = acc_r;
    k_s         = k_r;
    out_valid_s = out_valid_r;
    out_min_s   = out_min_r;
    out_fill_s  = out_fill_r;
    wr_en_s     = 1'b0;
`ifdef MINWIN_AGE_EN
    acc_age_s   = acc_age_r;
    out_age_s   = out_age_r;
`endif
    if (clr) begin
      // flush drops any pending result but leaves the last reported values
      state_s     = ST_IDLE;
      wptr_s      = '0;
      fill_s      = '0;
      out_valid_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.in_valid) begin
            wr_en_s = 1'b1;
            wptr_s  = wptr_inc_s;
            fill_s  = fill_inc_s;
            // the new sample is age 0, so it seeds the accumulator directly
            acc_s   = bus.in_data;
            k_s     = AW'(1);
`ifdef MINWIN_AGE_EN
            acc_age_s = '0;
`endif
            if (fill_inc_s == (AW+1)'(1)) begin
              state_s     = ST_HOLD;
              out_valid_s = 1'b1;
              out_min_s   = bus.in_data;
              out_fill_s  = fill_inc_s;
`ifdef MINWIN_AGE_EN
              out_age_s   = '0;
`endif
            end else begin
              state_s = ST_SCAN;
            end
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_SCAN: begin
          // strict < while walking newest to oldest: the youngest tie wins
          if (cand_s < acc_r) begin
            acc_s = cand_s;
`ifdef MINWIN_AGE_EN
            acc_age_s = k_r;
`endif
          end else begin
            acc_s = acc_r;
          end
          if (scan_last_s) begin
            state_s     = ST_HOLD;
            out_valid_s = 1'b1;
            out_min_s   = acc_s;
            out_fill_s  = fill_r;
`ifdef MINWIN_AGE_EN
            out_age_s   = acc_age_s;
`endif
          end else begin
            k_s = k_r + AW'(1);
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            state_s     = ST_IDLE;
            out_valid_s = 1'b0;
          end else begin
            state_s = ST_HOLD;
          end
        end
        default: begin
          state_s     = ST_IDLE;
          out_valid_s = 1'b0;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_r      <= '0;
      fill_r      <= '0;
      acc_r       <= '0;
      k_r         <= '0;
      out_valid_r <= 1'b0;
      out_min_r   <= '0;
      out_fill_r  <= '0;
`ifdef MINWIN_AGE_EN
      acc_age_r   <= '0;
      out_age_r   <= '0;
`endif
    end else begin
      wptr_r      <= wptr_s;
      fill_r      <= fill_s;
      acc_r       <= acc_s;
      k_r         <= k_s;
      out_valid_r <= out_valid_s;
      out_min_r   <= out_min_s;
      out_fill_r  <= out_fill_s;
`ifdef MINWIN_AGE_EN
      acc_age_r   <= acc_age_s;
      out_age_r   <= out_age_s;
`endif
    end
  end

  // Sample storage; no reset because fill gates every read.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      buf_r[wptr_r] <= bus.in_data;
    end
  end

  assign bus.in_ready  = (state_r == ST_IDLE);
  assign bus.out_valid = out_valid_r;
  assign bus.out_min   = out_min_r;
  assign bus.out_fill  = out_fill_r;
`ifdef MINWIN_AGE_EN
  assign bus.out_age   = out_age_r;
`endif

endmodule
